// File: rtl/telem_frame_tx_pkg.sv
// Shared constants, state encoding and checksum helper for the telemetry frame transmitter.
package telem_frame_tx_pkg;

    localparam int         FRAME_LEN       = 6;
    localparam logic [7:0] HEADER_DEFAULT  = 8'hA5;
    localparam int         STATUS_WARN_BIT = 0;
    localparam int         BYTE_IDX_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    function automatic logic [7:0] frame_checksum(
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3,
        input logic [7:0] b4
    );
        return b1 ^ b2 ^ b3 ^ b4;
    endfunction

endpackage

// File: rtl/telem_frame_tx_uart.sv
// 8N1 byte serializer, LSB first, each bit held DIV cycles. A load accepted in the
// last stop-bit cycle chains straight into the next start bit with no idle gap.
module uart_tx_byte
    import telem_frame_tx_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       ready_o
);

    localparam int            DW       = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    tx_state_e     state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          tick;
    logic [2:0]    bit_inc;

    assign tick    = (div_q == DIV_LAST);
    assign bit_inc = bit_q + 3'd1;
    // Ready in idle, or on the final cycle of a stop bit so bytes can abut.
    assign ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
    assign tx_o    = tx_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        if (state_q != ST_IDLE) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d = ST_START;
                    shift_d = data_i;
                    div_d   = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_inc;
                        tx_d  = shift_q[bit_inc];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (load_i) begin
                        state_d = ST_START;
                        shift_d = data_i;
                        bit_d   = '0;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/telem_frame_tx.sv
// Telemetry frame transmitter: snapshots the status inputs on start and sends
// HEADER, promedio, temp_high, temp_low, status, checksum as back-to-back 8N1 bytes.
module telem_frame_tx
    import telem_frame_tx_pkg::*;
#(
    parameter int         CLK_FREQ = 10000,
    parameter int         BAUD     = 1000,
    parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] promedio,
    input  logic [7:0] temp_high,
    input  logic [7:0] temp_low,
    input  logic       temp_warn,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                    DIV      = CLK_FREQ / BAUD;
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(FRAME_LEN - 1);

    generate
        if ((DIV < 2) || ((CLK_FREQ % BAUD) != 0)) begin : g_bad_div
            $error("telem_frame_tx: CLK_FREQ/BAUD must be an integer >= 2");
        end
    endgenerate

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [7:0]            prom_q, prom_d;
    logic [7:0]            thigh_q, thigh_d;
    logic [7:0]            tlow_q, tlow_d;
    logic                  warn_q, warn_d;

    logic [7:0]            status_byte;
    logic [7:0]            frame_byte [FRAME_LEN];
    logic [BYTE_IDX_W-1:0] next_idx;
    logic [7:0]            next_byte;
    logic                  ser_load;
    logic [7:0]            ser_data;
    logic                  ser_ready;

    always_comb begin
        status_byte                  = '0;
        status_byte[STATUS_WARN_BIT] = warn_q;
    end

    // Frame bytes are built from the snapshot only, so the checksum matches what was sent.
    assign frame_byte[0] = HEADER;
    assign frame_byte[1] = prom_q;
    assign frame_byte[2] = thigh_q;
    assign frame_byte[3] = tlow_q;
    assign frame_byte[4] = status_byte;
    assign frame_byte[5] = frame_checksum(prom_q, thigh_q, tlow_q, status_byte);

    assign next_idx = byte_idx_q + 1'b1;

    always_comb begin
        next_byte = HEADER;
        case (next_idx)
            3'd1:    next_byte = frame_byte[1];
            3'd2:    next_byte = frame_byte[2];
            3'd3:    next_byte = frame_byte[3];
            3'd4:    next_byte = frame_byte[4];
            3'd5:    next_byte = frame_byte[5];
            default: next_byte = frame_byte[0];
        endcase
    end

    always_comb begin
        busy_d     = busy_q;
        done_d     = 1'b0;
        byte_idx_d = byte_idx_q;
        prom_d     = prom_q;
        thigh_d    = thigh_q;
        tlow_d     = tlow_q;
        warn_d     = warn_q;
        ser_load   = 1'b0;
        ser_data   = HEADER;
        if (!busy_q) begin
            if (start) begin
                busy_d     = 1'b1;
                byte_idx_d = '0;
                prom_d     = promedio;
                thigh_d    = temp_high;
                tlow_d     = temp_low;
                warn_d     = temp_warn;
                ser_load   = 1'b1;
                ser_data   = HEADER;
            end
        end else if (ser_ready) begin
            // While busy the serializer is never idle, so ready marks the end of a stop bit.
            if (byte_idx_q == LAST_IDX) begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                byte_idx_d = '0;
            end else begin
                byte_idx_d = next_idx;
                ser_load   = 1'b1;
                ser_data   = next_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_idx_q <= '0;
            prom_q     <= '0;
            thigh_q    <= '0;
            tlow_q     <= '0;
            warn_q     <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            byte_idx_q <= byte_idx_d;
            prom_q     <= prom_d;
            thigh_q    <= thigh_d;
            tlow_q     <= tlow_d;
            warn_q     <= warn_d;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load),
        .data_i  (ser_data),
        .tx_o    (tx),
        .ready_o (ser_ready)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_telem_frame_tx.sv
// Scoreboard bench: stimulus queues expected frame bytes; a UART decoder pops and compares.
module tb_telem_frame_tx;

    localparam int CLK_FREQ  = 10000;
    localparam int BAUD      = 1000;
    localparam int DIV       = 10;
    localparam int FRAME_CYC = 60 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] promedio = '0;
    logic [7:0] temp_high = '0;
    logic [7:0] temp_low = '0;
    logic       temp_warn = 1'b0;
    logic       tx, busy, done;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         busy_run = 0;
    int         byte_no = 0;
    logic       prev_done = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] exp_q [$];

    telem_frame_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .HEADER   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .promedio  (promedio),
        .temp_high (temp_high),
        .temp_low  (temp_low),
        .temp_warn (temp_warn),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push6(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
        exp_q.push_back(b5);
    endtask

    task automatic set_inputs(input logic [7:0] p, input logic [7:0] h, input logic [7:0] l, input logic w);
        promedio  = p;
        temp_high = h;
        temp_low  = l;
        temp_warn = w;
    endtask

    // Returns with the acceptance edge as the most recent posedge (+1 time unit).
    task automatic start_pulse();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at_cyc);
        bit got;
        got    = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got    = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic skip(input int n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    // UART decoder: samples each bit at mid-period and scores completed bytes.
    initial begin : uart_mon
        logic [7:0] b;
        logic [7:0] e;
        bit         ok;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                b = '0;
                skip(DIV / 2, ok);
                if (ok) check("start_bit", tx, 1'b0);
                for (int i = 0; i < 8 && ok; i++) begin
                    skip(DIV, ok);
                    if (ok) b[i] = tx;
                end
                if (ok) skip(DIV, ok);
                if (ok) begin
                    check("stop_bit", tx, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none", b);
                    end else begin
                        e = exp_q.pop_front();
                        $display("byte %0d: got %02h expected %02h", byte_no, b, e);
                        check("frame_byte", b, e);
                    end
                    byte_no++;
                end
            end
        end
    end

    initial begin : busy_mon
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_run = 0;
            end else if (busy === 1'b1) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, FRAME_CYC);
                busy_run = 0;
            end
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (!rst && done === 1'b1) begin
                check("done_busy_low", busy, 1'b0);
                check("done_tx_idle", tx, 1'b1);
                check("done_single_cycle", prev_done, 1'b0);
                check("done_after_busy", prev_busy, 1'b1);
                done_cnt++;
            end
            prev_done = rst ? 1'b0 : done;
            prev_busy = rst ? 1'b0 : busy;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  t1, t2, dc;
        bit  idle_bad;

        // Reset and idle
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle_bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad = 1'b1;
        end
        check("idle_quiet", idle_bad, 1'b0);

        // Basic frame
        set_inputs(8'h3C, 8'h50, 8'h40, 1'b1);
        push6(8'hA5, 8'h3C, 8'h50, 8'h40, 8'h01, 8'h2D);
        start_pulse();
        @(negedge clk);
        check("accept_tx_low", tx, 1'b0);
        check("accept_busy", busy, 1'b1);
        wait_done(FRAME_CYC + 20, t1);
        repeat (5) @(negedge clk);
        check("done_count_basic", done_cnt, 1);

        // Snapshot: inputs change one cycle after acceptance
        start_pulse();
        @(posedge clk);
        #1 set_inputs(8'hFF, 8'hFF, 8'hFF, 1'b1);
        push6(8'hA5, 8'h3C, 8'h50, 8'h40, 8'h01, 8'h2D);
        wait_done(FRAME_CYC + 20, t1);
        repeat (5) @(negedge clk);

        // Second data pattern, warn clear
        set_inputs(8'h00, 8'hFF, 8'h0F, 1'b0);
        push6(8'hA5, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'hF0);
        start_pulse();
        wait_done(FRAME_CYC + 20, t1);
        repeat (5) @(negedge clk);

        // Start while busy at cycles 100 and 599 is ignored
        set_inputs(8'h3C, 8'h50, 8'h40, 1'b1);
        push6(8'hA5, 8'h3C, 8'h50, 8'h40, 8'h01, 8'h2D);
        dc = done_cnt;
        start_pulse();
        repeat (99) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (498) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(FRAME_CYC + 20, t1);
        repeat (FRAME_CYC + 50) @(negedge clk);
        check("busy_start_ignored", done_cnt, dc + 1);
        check("busy_queue_drained", exp_q.size(), 0);

        // Back-to-back frames with start held high
        push6(8'hA5, 8'h3C, 8'h50, 8'h40, 8'h01, 8'h2D);
        push6(8'hA5, 8'h3C, 8'h50, 8'h40, 8'h01, 8'h2D);
        @(posedge clk);
        #1 start = 1'b1;
        wait_done(FRAME_CYC + 20, t1);
        check("b2b_gap_idle", tx, 1'b1);
        @(negedge clk);
        check("b2b_restart_tx", tx, 1'b0);
        check("b2b_restart_busy", busy, 1'b1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(FRAME_CYC + 20, t2);
        check("b2b_done_spacing", t2 - t1, FRAME_CYC + 1);
        repeat (20) @(negedge clk);

        // Reset during byte 2, bit 3
        push6(8'hA5, 8'h3C, 8'h50, 8'h40, 8'h01, 8'h2D);
        start_pulse();
        repeat (244) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        dc = done_cnt;
        repeat (100) @(negedge clk);
        check("abort_no_done", done_cnt, dc);

        // Fresh frame after the abort
        set_inputs(8'h81, 8'h12, 8'h34, 1'b1);
        push6(8'hA5, 8'h81, 8'h12, 8'h34, 8'h01, 8'hA6);
        start_pulse();
        wait_done(FRAME_CYC + 20, t1);
        repeat (20) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/telem_frame_tx.md
Name: telem_frame_tx

Overview:
- Transmit-side counterpart of the command receiver path.
- The receiver/controller accepts command bytes from the host. This block sends telemetry frames back to the host over the UART tx line.
- On a start request it snapshots the averaged count, both hysteresis thresholds and the warning flag. It then serializes a fixed 6-byte checksummed frame as 8N1.
- It sits beside the send-data FSM: that FSM drives start, and this block drives tx.

Parameters:
- CLK_FREQ, 10000, input clock frequency in Hz.
- BAUD, 1000, line rate in bit/s. DIV = CLK_FREQ/BAUD is the clock cycles per bit. DIV must be an integer ≥ 2; otherwise elaboration fails.
- HEADER, 8'hA5, frame sync byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only while busy=0.
- promedio  in  8  averaged oscillator count.
- temp_high  in  8  upper threshold register.
- temp_low  in  8  lower threshold register.
- temp_warn  in  1  hysteresis warning flag.
- tx  out  1  UART serial output, idle high.
- busy  out  1  high from frame acceptance until the last stop bit ends.
- done  out  1  one-cycle pulse after the frame completes.

Behaviour:
- Reset values (rst=1 at an edge):
  - tx=1, busy=0, done=0.
  - FSM=IDLE; bit counter, byte index and divider count = 0.
  - Snapshot registers = 0.
  - Reset mid-frame aborts the frame immediately: tx returns high next cycle and no done pulse is issued.
- Frame layout (byte0 first):
  - B0 = HEADER
  - B1 = promedio
  - B2 = temp_high
  - B3 = temp_low
  - B4 = {7'b0, temp_warn}
  - B5 = B1^B2^B3^B4
- Snapshot: all inputs are latched on the edge where start is accepted. Input changes during the frame have no effect, and the checksum uses the snapshot values.
- Byte format: 8N1, LSB first. Each bit is held exactly DIV cycles. No idle gap between bytes: the stop bit of Bn is followed directly by the start bit of Bn+1.
- FSM states and transitions:
  - IDLE: tx=1. If start is high, latch the snapshot, set byte index=0 and go to START.
  - START: tx=0 for DIV cycles, then go to DATA with bit=0.
  - DATA: tx=byte[bit] for DIV cycles each. After bit 7 go to STOP.
  - STOP: tx=1 for DIV cycles. If byte index=5, go to IDLE and pulse done. Otherwise increment the byte index and go to START.
- Timing (acceptance edge = cycle 0):
  - tx falls low and busy rises at cycle 0's registered output.
  - busy stays high for exactly 60·DIV cycles.
  - done=1 in the first IDLE cycle, the same cycle busy drops.
- start while busy=1 is ignored, not queued.
- start high in the done cycle is accepted, giving back-to-back frames with a 1-cycle idle-high gap.
- start held high continuously produces repeated frames, each separated by one idle cycle.
- tx is driven from a register, so there are no glitches.
- Divider width is $clog2(DIV), and the divider wraps at DIV-1.

Decomposition:
- Shared package constants:
  - FRAME_LEN=6
  - HEADER default
  - state encoding: IDLE, START, DATA, STOP
  - STATUS bit index for temp_warn (bit 0)
- Sub-module uart_tx_byte: DIV-based bit serializer with handshake ports load, data[7:0], tx, ready.
- telem_frame_tx owns the snapshot registers, byte mux, checksum and frame counter.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> tx=1, busy=0, done=0. With start=0 for 100 cycles, tx stays 1.
- Basic frame, DIV=10: promedio=8'h3C, temp_high=8'h50, temp_low=8'h40, temp_warn=1, start pulse.
  - Decoded bytes: A5 3C 50 40 01 2D.
  - busy is high exactly 600 cycles, then done is a single 1-cycle pulse.
  - Every bit sampled mid-period is correct.
- Snapshot: change all inputs to 8'hFF one cycle after acceptance -> frame is still A5 3C 50 40 01 2D.
- Start while busy: pulse start at cycles 100 and 599 -> both ignored; exactly one frame and one done.
- Back-to-back: hold start=1 -> two consecutive frames, one idle-high cycle between the first frame's last stop bit and the second's start bit, and two done pulses 601 cycles apart.
- Reset mid-frame: assert rst during B2 bit 3 -> next cycle tx=1 and busy=0, no done. A new start afterwards yields a correct full frame.
